// File: rtl/riscv_run_ctrl.sv
// Run controller for the single-cycle RISC-V core: sequences core reset, runs the program,
// counts cycles/retires and ends the run on tohost write, self-loop halt or timeout.
module riscv_run_ctrl #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned RST_HOLD    = 4,
   parameter int unsigned MAX_CYCLES  = 40,
   parameter int unsigned STALL_LIMIT = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic             retire,
   input  logic [XLEN-1:0]  pc,
   input  logic             tohost_we,
   input  logic [XLEN-1:0]  tohost_data,
   output logic             core_reset,
   output logic             running,
   output logic             done,
   output logic             pass,
   output logic [1:0]       cause,
   output logic [XLEN-1:0]  fail_code,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] instret_count
);

   localparam int unsigned HOLD_W  = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
   localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);

   localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RST_HOLD - 1);
   localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);
   localparam logic [CNT_W-1:0]   CYC_MAX   = CNT_W'(MAX_CYCLES);

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_TOHOST  = 2'b01;
   localparam logic [1:0] CAUSE_SELF    = 2'b10;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      RUN,
      DONE
   } state_t;

   state_t              state;
   logic [HOLD_W-1:0]   hold_cnt;
   logic [STALL_W-1:0]  stall_cnt;
   logic [XLEN-1:0]     last_pc;

   logic [CNT_W-1:0]    cyc_inc;
   logic [CNT_W-1:0]    ins_inc;
   logic [STALL_W-1:0]  stall_nxt;
   logic                stall_hit;
   logic                time_hit;
   logic                arm;

   always_comb begin
      cyc_inc = (cycle_count == '1) ? cycle_count : cycle_count + CNT_W'(1);
      ins_inc = (retire && (instret_count != '1)) ? instret_count + CNT_W'(1) : instret_count;

      // A fresh stall count starts at 0, so the first retire lands on 1 either way
      stall_nxt = stall_cnt;
      if (retire) begin
         if (pc != last_pc)
            stall_nxt = STALL_W'(1);
         else if (stall_cnt != STALL_MAX)
            stall_nxt = stall_cnt + STALL_W'(1);
      end
      stall_hit = (stall_nxt == STALL_MAX);
      time_hit  = (cyc_inc >= CYC_MAX);

      // start+abort together in DONE resolves to IDLE, so it must not arm
      arm = start && ((state == IDLE) || ((state == DONE) && !abort));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         hold_cnt      <= '0;
         stall_cnt     <= '0;
         last_pc       <= '0;
         core_reset    <= 1'b1;
         running       <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         cause         <= CAUSE_NONE;
         fail_code     <= '0;
         cycle_count   <= '0;
         instret_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               core_reset <= 1'b1;
               running    <= 1'b0;
            end
            HOLD: begin
               core_reset <= 1'b1;
               running    <= 1'b0;
               if (abort) begin
                  state <= IDLE;
               end else if (hold_cnt == HOLD_LAST) begin
                  state      <= RUN;
                  core_reset <= 1'b0;
                  running    <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
               end
            end
            RUN: begin
               cycle_count   <= cyc_inc;
               instret_count <= ins_inc;
               stall_cnt     <= stall_nxt;
               if (retire)
                  last_pc <= pc;
               if (abort) begin
                  state      <= IDLE;
                  core_reset <= 1'b1;
                  running    <= 1'b0;
               end else if (tohost_we) begin
                  state      <= DONE;
                  core_reset <= 1'b1;
                  running    <= 1'b0;
                  done       <= 1'b1;
                  cause      <= CAUSE_TOHOST;
                  pass       <= (tohost_data == XLEN'(1));
                  fail_code  <= tohost_data >> 1;
               end else if (stall_hit) begin
                  state      <= DONE;
                  core_reset <= 1'b1;
                  running    <= 1'b0;
                  done       <= 1'b1;
                  cause      <= CAUSE_SELF;
                  pass       <= 1'b0;
               end else if (time_hit) begin
                  state      <= DONE;
                  core_reset <= 1'b1;
                  running    <= 1'b0;
                  done       <= 1'b1;
                  cause      <= CAUSE_TIMEOUT;
                  pass       <= 1'b0;
               end
            end
            DONE: begin
               core_reset <= 1'b1;
               running    <= 1'b0;
               if (abort)
                  state <= IDLE;
            end
            default: begin
               state      <= IDLE;
               core_reset <= 1'b1;
               running    <= 1'b0;
            end
         endcase

         if (arm) begin
            state         <= HOLD;
            hold_cnt      <= '0;
            stall_cnt     <= '0;
            last_pc       <= '0;
            core_reset    <= 1'b1;
            running       <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            cause         <= CAUSE_NONE;
            fail_code     <= '0;
            cycle_count   <= '0;
            instret_count <= '0;
         end
      end
   end

endmodule
